instr_encoder: RTL and testbench
================================

# instr_encoder

Inverse of the instruction decoder in the single-cycle core: accepts decoded RV32I fields (opcode, funct3, funct7, rd, rs1, rs2, immediate) over a valid/ready handshake, packs them into a 32-bit instruction word, checks immediate legality, and streams legal words with a running byte address toward the instruction-memory loader. Used by the program-load path and by test infrastructure to build instruction images from field-level descriptions.

## Interface
- FIFO_DEPTH, 2: output buffer entries; power of two, ≥2.
- BASE_ADDR, 32'h0000_0000: address of the first emitted word after reset or flush.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear: empties the FIFO and reloads the address to BASE_ADDR.
- in_valid  in  1  field set presented.
- in_ready  out  1  equals !fifo_full.
- opcode  in  type_opcode_e  instruction class.
- funct3  in  3, funct7  in  7, rd  in  5, rs1  in  5, rs2  in  5: raw fields.
- immediate  in  32  sign-extended immediate, in the decoder's format.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word.
- out_instr  out  32  encoded word at the FIFO head.
- out_addr  out  32  byte address paired with out_instr.
- err  out  1  one-cycle pulse when an illegal field set is consumed.
- err_count  out  8  count of illegal sets; saturates at 8'hFF.

## Operation
- Encoding is combinational from the inputs; a push occurs when in_valid && in_ready && !flush.
- R_TYPE: {funct7, rs2, rs1, funct3, rd, opcode}.
- I_TYPE, funct3 001/101: {funct7, imm[4:0], rs1, funct3, rd, opcode}. Legal only if imm[31:5]==0.
- I_TYPE (other funct3), LOAD_I, JALR_I: {imm[11:0], rs1, funct3, rd, opcode}. Legal only if imm[31:11] are all equal.
- S_TYPE: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}. Uses the same 12-bit sign rule.
- B_TYPE: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}. Legal only if imm[0]==0 and imm[31:12] are all equal.
- J_TYPE: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}. Legal only if imm[0]==0 and imm[31:20] are all equal.
- LUI_I, AUIPC: {imm[31:12], rd, opcode}. Legal only if imm[11:0]==0.
- Any other opcode value is illegal.
- An illegal set is consumed (handshake completes) and is not written to the FIFO. It pulses err and increments err_count. The address is not advanced.
- Legal words enter the FIFO tagged with the current address. The address then advances by 4 and wraps modulo 2^32.
- Reset values:
  - in_ready=1, out_valid=0, out_instr=0, out_addr=0, err=0, err_count=0.
  - Internal address = BASE_ADDR; FIFO empty.

## Timing
- Latency: a word pushed on edge N is visible on out_* in cycle N+1. There is no combinational bypass from inputs to outputs.
- Pop occurs on out_valid && out_ready. out_instr/out_addr hold stable while out_valid && !out_ready.
- Full FIFO: in_ready=0, so no push. A pop in the same cycle does not raise in_ready until the next cycle.
- Empty FIFO with a simultaneous push: out_valid rises on the next cycle.
- Push and pop in the same cycle (not full, not empty): occupancy is unchanged.
- flush dominates push and pop: the FIFO empties and the address reloads on that edge. err_count is retained.
- Asynchronous reset mid-stream drops all buffered words immediately and returns every output to its reset value.

## Structure
- Shared header single_cycle_defs.vh carries type_opcode_e with values R_TYPE=7'b0110011, I_TYPE=7'b0010011, LOAD_I=7'b0000011, S_TYPE=7'b0100011, B_TYPE=7'b1100011, JALR_I=7'b1100111, J_TYPE=7'b1101111, LUI_I=7'b0110111, AUIPC=7'b0010111.
- The encode and legality logic sits in this module as one always_comb block.
- Sub-module instr_fifo: synchronous FIFO, width 64 ({addr, instr}), depth FIFO_DEPTH, with full/empty flags and flush.

## Test plan
- addi x1,x0,5 (I_TYPE, f3=0, imm=5) -> out_instr=32'h00500093 at out_addr=0, one cycle after accept.
- beq x1,x2,-8 (imm=32'hFFFF_FFF8) then lui x5 with imm=32'h1234_5000 -> 32'hFE208CE3 @0, then 32'h123452B7 @4.
- srai x3,x4,7 (f3=101, f7=7'b0100000) -> 32'h40725193. The same op with imm=32 -> err pulse, err_count=1, no word output, address unchanged.
- jal with imm=3 -> err pulse, no output. A following legal op is emitted at the address that would have been next.
- Hold out_ready=0 and offer 3 words -> in_ready drops after 2 and outputs stay stable. Release -> words appear in order at 0, 4, 8.
- Assert rst_n low with 2 words buffered, then release -> out_valid=0, err_count=0, and the next word is at BASE_ADDR. flush behaves the same way except err_count is retained.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg
// Shared definitions for the instruction encoder: the RV32I opcode classes
// (mirroring the single-cycle core's decoder), datapath widths, and a helper
// that tests whether an immediate fits a sign-extended field.
package instr_encoder_pkg;

    // Instruction classes as seen by the single-cycle core's decoder.
    typedef enum logic [6:0] {
        R_TYPE = 7'b0110011,
        I_TYPE = 7'b0010011,
        LOAD_I = 7'b0000011,
        S_TYPE = 7'b0100011,
        B_TYPE = 7'b1100011,
        JALR_I = 7'b1100111,
        J_TYPE = 7'b1101111,
        LUI_I  = 7'b0110111,
        AUIPC  = 7'b0010111
    } type_opcode_e;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

    // True when imm[31:msb] are all equal, i.e. the value survives truncation
    // to an (msb+1)-bit two's-complement field.
    function automatic logic signFits(input logic [31:0] imm, input int unsigned msb);
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << msb;
        return ((imm & mask) == mask) || ((imm & mask) == 32'h0);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if
// Bundles both streaming handshakes of the encoder.
//   in_valid/in_ready + opcode, funct3, funct7, rd, rs1, rs2, immediate :
//       decoded field set from the producer
//   out_valid/out_ready + out_instr, out_addr :
//       encoded word and its byte address toward the memory loader
// modport master : producer/consumer side (the environment)
// modport slave  : the encoder itself
interface instr_encoder_if;
    import instr_encoder_pkg::*;

    logic         in_valid;
    logic         in_ready;
    type_opcode_e opcode;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic [4:0]   rd;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [31:0]  immediate;

    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_instr;
    logic [31:0]  out_addr;

    modport master (
        output in_valid, opcode, funct3, funct7, rd, rs1, rs2, immediate, out_ready,
        input  in_ready, out_valid, out_instr, out_addr
    );

    modport slave (
        input  in_valid, opcode, funct3, funct7, rd, rs1, rs2, immediate, out_ready,
        output in_ready, out_valid, out_instr, out_addr
    );

endinterface

// File: rtl/instr_encoder_fifo.sv
// instr_fifo
// Synchronous FIFO holding {addr, instr} entries for the encoder.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : synchronous clear, dominates push and pop
//   push_i     : write data_i (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   data_o     : head entry, forced to zero while empty
//   full_o     : no free entries
//   empty_o    : no valid entries
module instr_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wrPtr_q;
    logic [PTR_W:0]   rdPtr_q;
    logic             doPush;
    logic             doPop;

    // Pointers carry one extra wrap bit so that equal indices can be told
    // apart as empty (same lap) or full (different lap).
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                     (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);

    assign doPush = push_i && !full_o && !flush_i;
    assign doPop  = pop_i && !empty_o && !flush_i;

    // Head is zeroed while empty so the outputs read as zero after reset or
    // flush rather than exposing stale storage.
    assign data_o = empty_o ? '0 : mem_q[rdPtr_q[PTR_W-1:0]];

    // Pointer bookkeeping; flush rewinds both pointers, dropping all entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else if (flush_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (doPush) mem_q[wrPtr_q[PTR_W-1:0]] <= data_i;
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
// Packs decoded RV32I fields into 32-bit instruction words, rejects field sets
// whose immediate cannot be represented, and streams legal words with a
// running byte address through a small output FIFO.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush_i     : synchronous clear of FIFO and address (error count kept)
//   bus         : field-set input and word/address output handshakes
//   err_o       : one-cycle pulse after an illegal field set is consumed
//   err_count_o : saturating count of illegal field sets
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    instr_encoder_if.slave        bus,
    output logic                  err_o,
    output logic [7:0]            err_count_o
);

    logic [31:0]        encWord;
    logic               encLegal;
    logic               accept;
    logic               fifoPush;
    logic               fifoPop;
    logic               fifoFull;
    logic               fifoEmpty;
    logic [ENTRY_W-1:0] headData;

    logic [31:0]        addr_q, addr_d;
    logic [7:0]         errCount_q, errCount_d;
    logic               err_q, err_d;

    // Field packing and immediate legality for every instruction class.
    // Shift-immediate forms reuse funct7 as the upper bits, so their
    // immediate must be a plain 5-bit shift amount.
    always_comb begin
        encWord  = 32'h0;
        encLegal = 1'b0;
        case (bus.opcode)
            R_TYPE: begin
                encWord  = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, R_TYPE};
                encLegal = 1'b1;
            end
            I_TYPE, LOAD_I, JALR_I: begin
                if (bus.opcode == I_TYPE && (bus.funct3 == 3'b001 || bus.funct3 == 3'b101)) begin
                    encWord  = {bus.funct7, bus.immediate[4:0], bus.rs1, bus.funct3,
                                bus.rd, bus.opcode};
                    encLegal = (bus.immediate[31:5] == 27'h0);
                end else begin
                    encWord  = {bus.immediate[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                    encLegal = signFits(bus.immediate, 11);
                end
            end
            S_TYPE: begin
                encWord  = {bus.immediate[11:5], bus.rs2, bus.rs1, bus.funct3,
                            bus.immediate[4:0], S_TYPE};
                encLegal = signFits(bus.immediate, 11);
            end
            B_TYPE: begin
                encWord  = {bus.immediate[12], bus.immediate[10:5], bus.rs2, bus.rs1,
                            bus.funct3, bus.immediate[4:1], bus.immediate[11], B_TYPE};
                encLegal = !bus.immediate[0] && signFits(bus.immediate, 12);
            end
            J_TYPE: begin
                encWord  = {bus.immediate[20], bus.immediate[10:1], bus.immediate[11],
                            bus.immediate[19:12], bus.rd, J_TYPE};
                encLegal = !bus.immediate[0] && signFits(bus.immediate, 20);
            end
            LUI_I, AUIPC: begin
                encWord  = {bus.immediate[31:12], bus.rd, bus.opcode};
                encLegal = (bus.immediate[11:0] == 12'h0);
            end
            default: begin
                encWord  = 32'h0;
                encLegal = 1'b0;
            end
        endcase
    end

    // Illegal sets still complete the handshake; only legal ones are stored.
    assign accept   = bus.in_valid && !fifoFull && !flush_i;
    assign fifoPush = accept && encLegal;
    assign fifoPop  = !fifoEmpty && bus.out_ready;

    assign bus.in_ready  = !fifoFull;
    assign bus.out_valid = !fifoEmpty;
    assign bus.out_addr  = headData[ENTRY_W-1:INSTR_W];
    assign bus.out_instr = headData[INSTR_W-1:0];

    assign err_o       = err_q;
    assign err_count_o = errCount_q;

    // Next address advances only for stored words; the error counter sticks
    // at its maximum instead of wrapping, and survives a flush.
    always_comb begin
        addr_d     = addr_q;
        errCount_d = errCount_q;
        err_d      = accept && !encLegal;
        if (flush_i) begin
            addr_d = BASE_ADDR;
        end else if (fifoPush) begin
            addr_d = addr_q + 32'd4;
        end
        if (err_d && errCount_q != 8'hFF) begin
            errCount_d = errCount_q + 8'd1;
        end
    end

    // Address, error pulse and error count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= BASE_ADDR;
            errCount_q <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            errCount_q <= errCount_d;
            err_q      <= err_d;
        end
    end

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_i),
        .push_i  (fifoPush),
        .pop_i   (fifoPop),
        .data_i  ({addr_q, encWord}),
        .data_o  (headData),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
// Directed program-load scenarios followed by a randomized stream, all
// compared against a transaction-level model of the encoder: a queue of
// expected {addr, word} entries, a running address and an error counter.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       err;
    logic [7:0] errCount;

    instr_encoder_if bus ();

    instr_encoder #(
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .bus         (bus),
        .err_o       (err),
        .err_count_o (errCount)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] expQ[$];
    logic [31:0] mAddr;
    logic        mErr;
    int          mErrCount;

    type_opcode_e ops [9] = '{R_TYPE, I_TYPE, LOAD_I, S_TYPE, B_TYPE,
                              JALR_I, J_TYPE, LUI_I, AUIPC};
    logic [31:0] bounds [12] = '{32'd2047, 32'hFFFF_F800, 32'd2048, 32'hFFFF_F7FF,
                                 32'd4094, 32'hFFFF_F000, 32'd4096, 32'h000F_FFFE,
                                 32'hFFF0_0000, 32'h0010_0000, 32'd31, 32'd32};

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoder: each instruction class described by value ranges
    // and arithmetic placement of fields rather than bit slicing.
    function automatic void modelEncode(input type_opcode_e op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm,
                                        output bit legal, output logic [31:0] word);
        int s;
        logic [31:0] common;
        s      = int'($signed(imm));
        common = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        legal  = 1'b0;
        word   = 32'h0;
        case (op)
            R_TYPE: begin
                legal = 1'b1;
                word  = (32'(f7) << 25) | (32'(rs2) << 20) | common | (32'(rd) << 7);
            end
            I_TYPE, LOAD_I, JALR_I: begin
                if (op == I_TYPE && (f3 == 3'd1 || f3 == 3'd5)) begin
                    legal = (imm < 32'd32);
                    word  = (32'(f7) << 25) | ((imm % 32) << 20) | common | (32'(rd) << 7);
                end else begin
                    legal = (s >= -2048) && (s <= 2047);
                    word  = ((imm % 4096) << 20) | common | (32'(rd) << 7);
                end
            end
            S_TYPE: begin
                legal = (s >= -2048) && (s <= 2047);
                word  = (((imm / 32) % 128) << 25) | (32'(rs2) << 20) | common |
                        ((imm % 32) << 7);
            end
            B_TYPE: begin
                legal = (imm % 2 == 0) && (s >= -4096) && (s <= 4095);
                word  = (((imm / 4096) % 2) << 31) | (((imm / 32) % 64) << 25) |
                        (32'(rs2) << 20) | common | (((imm / 2) % 16) << 8) |
                        (((imm / 2048) % 2) << 7);
            end
            J_TYPE: begin
                legal = (imm % 2 == 0) && (s >= -(1 << 20)) && (s <= (1 << 20) - 1);
                word  = (((imm / 32'h10_0000) % 2) << 31) | (((imm / 2) % 1024) << 21) |
                        (((imm / 2048) % 2) << 20) | (((imm / 4096) % 256) << 12) |
                        (32'(rd) << 7) | 32'(op);
            end
            LUI_I, AUIPC: begin
                legal = (imm % 4096 == 0);
                word  = imm | (32'(rd) << 7) | 32'(op);
            end
            default: begin
                legal = 1'b0;
                word  = 32'h0;
            end
        endcase
    endfunction

    task automatic resetModel();
        expQ.delete();
        mAddr     = BASE;
        mErr      = 1'b0;
        mErrCount = 0;
    endtask

    task automatic applyStimulus(input bit valid, input type_opcode_e op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm, input bit outReady);
        bus.in_valid  = valid;
        bus.opcode    = op;
        bus.funct3    = f3;
        bus.funct7    = f7;
        bus.rd        = rd;
        bus.rs1       = rs1;
        bus.rs2       = rs2;
        bus.immediate = imm;
        bus.out_ready = outReady;
    endtask

    task automatic checkOutput();
        chk("in_ready", 32'(bus.in_ready), 32'(expQ.size() < DEPTH));
        chk("out_valid", 32'(bus.out_valid), 32'(expQ.size() != 0));
        chk("err", 32'(err), 32'(mErr));
        chk("err_count", 32'(errCount), 32'(mErrCount));
        if (expQ.size() != 0) begin
            chk("out_instr", bus.out_instr, expQ[0][31:0]);
            chk("out_addr", bus.out_addr, expQ[0][63:32]);
        end
    endtask

    // One clock: decide accept/pop from the model's occupancy and the
    // pre-edge inputs, advance the model at the edge, compare at negedge.
    task automatic step();
        bit          acc;
        bit          pop;
        bit          legal;
        logic [31:0] word;
        acc = bus.in_valid && (expQ.size() < DEPTH) && !flush;
        pop = (expQ.size() != 0) && bus.out_ready;
        modelEncode(bus.opcode, bus.funct3, bus.funct7, bus.rd, bus.rs1, bus.rs2,
                    bus.immediate, legal, word);
        @(posedge clk);
        if (flush) begin
            expQ.delete();
            mAddr = BASE;
            mErr  = 1'b0;
        end else begin
            if (pop) void'(expQ.pop_front());
            if (acc && legal) begin
                expQ.push_back({mAddr, word});
                mAddr = mAddr + 32'd4;
            end
            mErr = acc && !legal;
            if (mErr && mErrCount < 255) mErrCount++;
        end
        @(negedge clk);
        checkOutput();
    endtask

    task automatic idle(input bit outReady);
        applyStimulus(1'b0, I_TYPE, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, outReady);
    endtask

    task automatic randomStimulus();
        type_opcode_e op;
        logic [31:0]  imm;
        if ($urandom_range(0, 11) == 0) op = type_opcode_e'(7'h7F);
        else op = ops[$urandom_range(0, 8)];
        case ($urandom_range(0, 5))
            0: imm = 32'($urandom_range(0, 63));
            1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: imm = $urandom & 32'hFFFF_FFFE;
            3: imm = $urandom & 32'hFFFF_F000;
            4: imm = bounds[$urandom_range(0, 11)];
            default: imm = $urandom;
        endcase
        applyStimulus(($urandom_range(0, 3) != 0), op, 3'($urandom), 7'($urandom),
                      5'($urandom), 5'($urandom), 5'($urandom), imm,
                      ($urandom_range(0, 2) != 0));
        flush = ($urandom_range(0, 39) == 0);
    endtask

    // Directed scenarios, then a randomized stream.
    initial begin
        flush = 1'b0;
        rst_n = 1'b0;
        idle(1'b1);
        resetModel();
        #1;
        checkOutput();
        chk("reset_instr", bus.out_instr, 32'h0);
        chk("reset_addr", bus.out_addr, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // addi x1,x0,5
        applyStimulus(1'b1, I_TYPE, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        step();
        chk("addi_word", bus.out_instr, 32'h0050_0093);
        chk("addi_addr", bus.out_addr, 32'h0);
        idle(1'b1);
        step();

        // beq then lui from a freshly flushed address
        flush = 1'b1;
        step();
        flush = 1'b0;
        applyStimulus(1'b1, B_TYPE, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b0);
        step();
        chk("beq_word", bus.out_instr, 32'hFE20_8CE3);
        chk("beq_addr", bus.out_addr, 32'h0);
        applyStimulus(1'b1, LUI_I, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
        step();
        chk("beq_hold", bus.out_instr, 32'hFE20_8CE3);
        idle(1'b1);
        step();
        chk("lui_word", bus.out_instr, 32'h1234_52B7);
        chk("lui_addr", bus.out_addr, 32'h4);
        step();

        // srai, then an out-of-range shift amount
        applyStimulus(1'b1, I_TYPE, 3'd5, 7'b0100000, 5'd3, 5'd4, 5'd0, 32'd7, 1'b1);
        step();
        chk("srai_word", bus.out_instr, 32'h4072_5193);
        chk("srai_addr", bus.out_addr, 32'h8);
        applyStimulus(1'b1, I_TYPE, 3'd5, 7'b0100000, 5'd3, 5'd4, 5'd0, 32'd32, 1'b1);
        step();
        chk("srai32_err", 32'(err), 32'd1);
        chk("srai32_cnt", 32'(errCount), 32'd1);
        chk("srai32_noword", 32'(bus.out_valid), 32'd0);

        // misaligned jal, then a legal op at the next unused address
        applyStimulus(1'b1, J_TYPE, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b1);
        step();
        chk("jal_err", 32'(err), 32'd1);
        applyStimulus(1'b1, I_TYPE, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd1, 1'b1);
        step();
        chk("after_err_word", bus.out_instr, 32'h0010_0113);
        chk("after_err_addr", bus.out_addr, 32'hC);
        chk("err_cleared", 32'(err), 32'd0);

        // back-pressure: three words into a two-entry buffer
        flush = 1'b1;
        idle(1'b0);
        step();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, I_TYPE, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0);
            step();
        end
        chk("full_ready", 32'(bus.in_ready), 32'd0);
        chk("full_head", bus.out_addr, 32'h0);
        applyStimulus(1'b1, I_TYPE, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd2, 1'b1);
        step();
        chk("release_addr4", bus.out_addr, 32'h4);
        step();
        chk("release_addr8", bus.out_addr, 32'h8);
        idle(1'b1);
        step();

        // asynchronous reset with two words buffered
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, R_TYPE, 3'd0, 7'd0, 5'(i), 5'd1, 5'd2, 32'd0, 1'b0);
            step();
        end
        rst_n = 1'b0;
        #1;
        resetModel();
        checkOutput();
        chk("areset_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, R_TYPE, 3'd0, 7'd0, 5'd7, 5'd1, 5'd2, 32'd0, 1'b1);
        step();
        chk("areset_base", bus.out_addr, BASE);
        idle(1'b1);
        step();

        // flush with two words buffered keeps the error count
        applyStimulus(1'b1, LUI_I, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0010, 1'b0);
        step();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, R_TYPE, 3'd0, 7'd0, 5'(i), 5'd3, 5'd4, 32'd0, 1'b0);
            step();
        end
        flush = 1'b1;
        idle(1'b0);
        step();
        flush = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_errcnt", 32'(errCount), 32'd1);
        applyStimulus(1'b1, R_TYPE, 3'd0, 7'd0, 5'd9, 5'd1, 5'd2, 32'd0, 1'b1);
        step();
        chk("flush_base", bus.out_addr, BASE);

        // randomized stream against the model
        for (int n = 0; n < 400; n++) begin
            randomStimulus();
            step();
        end
        flush = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
